// File: rtl/counter_sequencer.sv
// Command-driven controller for an 8-bit up-counter with terminal value, prescaler,
// one-shot/periodic modes and pause/resume. All outputs are registered.
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wrap,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_SET_TOP = 3'd2;
  localparam logic [2:0] OP_SET_DIV = 3'd3;
  localparam logic [2:0] OP_START   = 3'd4;
  localparam logic [2:0] OP_PAUSE   = 3'd5;
  localparam logic [2:0] OP_RESUME  = 3'd6;
  localparam logic [2:0] OP_STOP    = 3'd7;

  logic [1:0]       state_r, state_nx, run_nx;
  logic [WIDTH-1:0] count_r, count_nx;
  logic [WIDTH-1:0] top_r, top_nx;
  logic [WIDTH-1:0] div_r, div_nx;
  logic [WIDTH-1:0] presc_r, presc_nx;
  logic             mode_r, mode_nx;
  logic             wrap_r, wrap_nx;
  logic             ready_r;
  logic             done_r, done_nx;
  logic             accept_s, tick_s, step_s, discard_s, keep_step_s, terminal_s;

  // Step qualification; commands that own the counter suppress a colliding step.
  always_comb begin
    accept_s = cmd_valid && ready_r;
    tick_s   = (state_r == S_RUN) && ena;
    step_s   = tick_s && (presc_r == div_r);
    case (cmd_op)
      OP_LOAD, OP_SET_DIV, OP_START, OP_PAUSE, OP_STOP: discard_s = accept_s;
      default:                                          discard_s = 1'b0;
    endcase
    keep_step_s = step_s && !discard_s;
    terminal_s  = keep_step_s && (count_r >= top_r);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state: step outcome first, then any accepted command.
  always_comb begin
    run_nx   = (terminal_s && !mode_r) ? S_DONE : state_r;
    state_nx = run_nx;
    if (accept_s) begin
      case (cmd_op)
        OP_LOAD:   state_nx = (state_r == S_DONE)  ? S_IDLE  : state_r;
        OP_START:  state_nx = S_RUN;
        OP_PAUSE:  state_nx = (state_r == S_RUN)   ? S_PAUSE : state_r;
        OP_RESUME: state_nx = (state_r == S_PAUSE) ? S_RUN   : run_nx;
        OP_STOP:   state_nx = S_IDLE;
        default:   state_nx = run_nx;
      endcase
    end else begin
      state_nx = run_nx;
    end
  end

  // FSM outputs, computed from the next state so they register alongside it.
  always_comb begin
    done_nx = (state_nx == S_DONE);
    wrap_nx = terminal_s;
  end

  // Datapath next values.
  always_comb begin
    top_nx  = top_r;
    div_nx  = div_r;
    mode_nx = mode_r;
    if (tick_s) begin
      presc_nx = (presc_r == div_r) ? '0 : presc_r + WIDTH'(1);
    end else begin
      presc_nx = presc_r;
    end
    if (keep_step_s) begin
      count_nx = terminal_s ? '0 : count_r + WIDTH'(1);
    end else begin
      count_nx = count_r;
    end
    if (accept_s) begin
      case (cmd_op)
        OP_LOAD: begin
          count_nx = cmd_data;
          presc_nx = '0;
        end
        OP_SET_TOP: top_nx = cmd_data;
        OP_SET_DIV: begin
          div_nx   = cmd_data;
          presc_nx = '0;
        end
        OP_START: begin
          mode_nx  = cmd_data[0];
          presc_nx = '0;
        end
        OP_PAUSE: presc_nx = presc_r;
        OP_STOP: begin
          count_nx = '0;
          presc_nx = '0;
        end
        default: top_nx = top_r;
      endcase
    end else begin
      top_nx = top_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
      top_r   <= '1;
      div_r   <= '0;
      presc_r <= '0;
      mode_r  <= 1'b0;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      count_r <= count_nx;
      top_r   <= top_nx;
      div_r   <= div_nx;
      presc_r <= presc_nx;
      mode_r  <= mode_nx;
      wrap_r  <= wrap_nx;
      done_r  <= done_nx;
      ready_r <= 1'b1;
    end
  end

  assign count     = count_r;
  assign state     = state_r;
  assign wrap      = wrap_r;
  assign done      = done_r;
  assign cmd_ready = ready_r;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences an 8-bit up-counter datapath: loads it, sets its terminal value and prescale rate, and runs it in one-shot or periodic mode with pause and resume. It sits between the design's command source (the pin-level decoder on the TinyTapeout top) and the count output bus. It replaces the free-running counter with a programmable, stoppable timer/counter.

## Interface
- WIDTH, 8, width of count, top, divider and cmd_data
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- ena  in  1  count enable; prescaler and steps advance only when 1
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WIDTH  opcode operand
- count  out  WIDTH  current count, registered
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
- wrap  out  1  one-cycle pulse, registered; high in the cycle count first shows 0 after a terminal step
- done  out  1  high while state == DONE

## Operation
- Internal registers: top (terminal value), div (prescale), presc (prescale counter), mode (0 one-shot, 1 periodic).
- Reset (rst_n low at edge): count 0, top all-ones, div 0, presc 0, mode 0, state IDLE, wrap 0, cmd_ready 0.
- cmd_ready is registered: 0 while in reset, 1 from the first edge with rst_n high onward. It is never otherwise deasserted.
- Step generation: only in RUN with ena=1. If presc == div, then presc <= 0 and a step occurs. Otherwise presc <= presc+1 and no step occurs. With ena=0, presc holds.
- Step: if count >= top, count <= 0, wrap pulses, and in one-shot mode state <= DONE. Otherwise count <= count+1. Comparison is unsigned >=, so a count above top wraps on its next step.
- Opcodes (take effect at the accepting edge):
  - 0 NOP: no effect.
  - 1 LOAD: count <= cmd_data; presc <= 0. State is unchanged, except DONE → IDLE.
  - 2 SET_TOP: top <= cmd_data.
  - 3 SET_DIV: div <= cmd_data; presc <= 0.
  - 4 START: mode <= cmd_data[0]; presc <= 0; state <= RUN from any state. count is unchanged.
  - 5 PAUSE: RUN → PAUSE; presc holds. Ignored in other states.
  - 6 RESUME: PAUSE → RUN; presc continues from its held value. Ignored in other states.
  - 7 STOP: state <= IDLE; count <= 0; presc <= 0.
- Command/step collision in the same cycle:
  - LOAD, SET_DIV, START, PAUSE, STOP: the step is discarded, including any wrap and DONE transition.
  - NOP, SET_TOP, RESUME: the step proceeds, evaluated against the old top.
- IDLE, PAUSE and DONE: count holds, and wrap stays 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Command latency is 1 cycle: the effect is visible in the cycle after the accepting edge.
- START accepted at edge k with div=d and ena held 1: the first step occurs at edge k+d+1, then every d+1 edges after that.
- Terminal step at edge n: at n, count becomes 0 and wrap becomes 1; wrap returns to 0 at n+1. In one-shot mode, state=DONE and done=1 from edge n.
- rst_n low at any edge, including mid-RUN or together with cmd_valid: the reset values apply and the command is dropped.
- WIDTH arithmetic: count+1 and presc+1 never exceed WIDTH bits. The >= top rule guarantees the wrap, so neither increment overflows.

## Test plan
- Reset: hold rst_n low 2 cycles with cmd_valid=1, op STOP → count=0, state=0, wrap=0, done=0, cmd_ready=0. cmd_ready=1 one cycle after release.
- Periodic: SET_TOP 3, START data=1, div=0, ena=1 → count sequence 1,2,3,0,1,… with wrap high exactly when count shows 0, every 4 cycles.
- One-shot with prescale: SET_DIV 2, SET_TOP 2, START data=0 at edge k → count=1 at k+3, 2 at k+6, 0 at k+9 with wrap=1 and state=DONE; count holds 0 afterwards.
- Pause/resume and ena: RUN with div=1. PAUSE mid-prescale, hold 5 cycles, then RESUME → count frozen during the pause and the step interval resumes from the held presc. With ena=0 in RUN, count and presc freeze.
- Collisions: LOAD 8'h40 in a step cycle → count=8'h40 with no increment. SET_TOP 1 when count=5 in a step cycle → old top used, count=6. The next step then wraps to 0 because 6 >= 1.
- Reset mid-RUN: top=10, count=7, rst_n low 1 cycle → count=0, state=IDLE, top=8'hFF. START with top left at 8'hFF then counts to 255 and wraps.
